player_move_ctrl: RTL

Sequencer for the player sprite's position and colour registers: it arbitrates the four direction buttons, paces moves on a divided tick, and waits for a full rendered frame before acting on the collision flag. It applies bounce-back and colour toggle when a collision is seen. It sits between the button inputs, the pixel/collision path (collision, VBlank) and map_generator/colour mux, which consume playerPosX/playerPosY/playerColor.

---
 rtl/player_move_ctrl.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/player_move_ctrl.sv
// player_move_ctrl: sequencer for the player sprite position and colour.
// Arbitrates the four direction buttons and paces moves on a divided tick.
// After each one-pixel step it waits for one fully drawn frame, then acts on
// the collision seen in that frame with a bounce-back and a colour toggle.
//
// Ports:
//   clk_vga     in   pixel clock, all logic on the rising edge
//   RESET       in   synchronous active-high reset
//   BUTTON[3:0] in   level requests: [0] right, [1] down, [2] up, [3] left
//   VBlank      in   vertical blank from vga_driver
//   collision   in   per-pixel collision strobe from the colour path
//   playerPosX  out  sprite centre X (10 bits)
//   playerPosY  out  sprite centre Y (9 bits)
//   playerColor out  sprite colour RRRGGGBB
//   move_dir    out  direction of the last granted move (0 R, 1 D, 2 U, 3 L)
//   busy        out  high while the FSM is not in IDLE
//
// Optional feature macro: ROUND_ROBIN_EN. When it is defined, the grant uses
// rotating priority starting at (move_dir+1) mod 4. When it is undefined,
// the grant uses fixed priority 0 > 1 > 2 > 3.
module player_move_ctrl #(
  parameter int unsigned TICK_DIV   = 65536,
  parameter int unsigned X_MIN      = 16,
  parameter int unsigned X_MAX      = 624,
  parameter int unsigned Y_MIN      = 10,
  parameter int unsigned Y_MAX      = 470,
  parameter int unsigned X_START    = 320,
  parameter int unsigned Y_START    = 240,
  parameter int unsigned BOUNCE     = 7,
  parameter int unsigned COLOR_INIT = 8'h6F
) (
  input  logic       clk_vga,
  input  logic       RESET,
  input  logic [3:0] BUTTON,
  input  logic       VBlank,
  input  logic       collision,
  output logic [9:0] playerPosX,
  output logic [8:0] playerPosY,
  output logic [7:0] playerColor,
  output logic [1:0] move_dir,
  output logic       busy
);

  localparam int unsigned XW   = 10;
  localparam int unsigned YW   = 9;
  localparam int unsigned CW   = 8;
  localparam int unsigned CNTW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef logic [XW:0] xw_t;
  typedef logic [YW:0] yw_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEP   = 2'd1,
    SETTLE = 2'd2,
    BNC    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   pos_x_q, pos_x_d;
  logic [YW-1:0]   pos_y_q, pos_y_d;
  logic [CW-1:0]   color_q, color_d;
  logic [1:0]      move_dir_q, move_dir_d;
  logic            busy_q, busy_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            vblank_q;
  logic            coll_flag_q, coll_flag_d;
  logic            coll_frame_q, coll_frame_d;
  logic            vb_cnt_q, vb_cnt_d;

  logic            tick;
  logic            vb_rise;
  logic            coll_now;
  logic [3:0]      elig;
  logic            grant_vld;
  logic [1:0]      grant_dir;

  xw_t             x_plus, x_minus;
  yw_t             y_plus, y_minus;
  logic [XW-1:0]   x_bnc_up, x_bnc_dn;
  logic [YW-1:0]   y_bnc_up, y_bnc_dn;

  assign tick    = (cnt_q == CNTW'(TICK_DIV - 1));
  assign vb_rise = VBlank & ~vblank_q;
  // Value coll_frame takes on this edge. The decision at the second VBlank
  // rise must see the frame that just finished, not the previous one.
  assign coll_now = coll_flag_q | collision;

  // Per-direction bound checks.
  assign elig[0] = BUTTON[0] & (pos_x_q < XW'(X_MAX));
  assign elig[1] = BUTTON[1] & (pos_y_q < YW'(Y_MAX));
  assign elig[2] = BUTTON[2] & (pos_y_q > YW'(Y_MIN));
  assign elig[3] = BUTTON[3] & (pos_x_q > XW'(X_MIN));

  // Bounce targets, one bit wider so the clamp can see overflow and borrow.
  assign x_plus   = {1'b0, pos_x_q} + xw_t'(BOUNCE);
  assign x_minus  = {1'b0, pos_x_q} - xw_t'(BOUNCE);
  assign y_plus   = {1'b0, pos_y_q} + yw_t'(BOUNCE);
  assign y_minus  = {1'b0, pos_y_q} - yw_t'(BOUNCE);
  assign x_bnc_up = (x_plus > xw_t'(X_MAX)) ? XW'(X_MAX) : x_plus[XW-1:0];
  assign x_bnc_dn = (x_minus[XW] || (x_minus < xw_t'(X_MIN))) ? XW'(X_MIN)
                                                                : x_minus[XW-1:0];
  assign y_bnc_up = (y_plus > yw_t'(Y_MAX)) ? YW'(Y_MAX) : y_plus[YW-1:0];
  assign y_bnc_dn = (y_minus[YW] || (y_minus < yw_t'(Y_MIN))) ? YW'(Y_MIN)
                                                                : y_minus[YW-1:0];

  // Grant selection among the eligible buttons. The loop runs from the lowest
  // priority to the highest, so the last hit wins.
`ifdef ROUND_ROBIN_EN
  logic [1:0] rr_idx;
  always_comb begin
    grant_vld = 1'b0;
    grant_dir = 2'd0;
    rr_idx    = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      rr_idx = move_dir_q + 2'd1 + 2'(k);
      if (elig[rr_idx]) begin
        grant_vld = 1'b1;
        grant_dir = rr_idx;
      end
    end
  end
`else
  always_comb begin
    grant_vld = 1'b0;
    grant_dir = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (elig[2'(k)]) begin
        grant_vld = 1'b1;
        grant_dir = 2'(k);
      end
    end
  end
`endif

  // Next-state, datapath and collision capture.
  always_comb begin
    state_d      = state_q;
    pos_x_d      = pos_x_q;
    pos_y_d      = pos_y_q;
    color_d      = color_q;
    move_dir_d   = move_dir_q;
    vb_cnt_d     = vb_cnt_q;
    coll_flag_d  = coll_flag_q;
    coll_frame_d = coll_frame_q;
    cnt_d        = tick ? '0 : cnt_q + CNTW'(1);

    if (vb_rise) begin
      coll_frame_d = coll_now;
      coll_flag_d  = 1'b0;
    end else if (collision) begin
      coll_flag_d  = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (tick && grant_vld) begin
          move_dir_d = grant_dir;
          state_d    = STEP;
        end
      end
      STEP: begin
        unique case (move_dir_q)
          2'd0: pos_x_d = pos_x_q + XW'(1);
          2'd1: pos_y_d = pos_y_q + YW'(1);
          2'd2: pos_y_d = pos_y_q - YW'(1);
          2'd3: pos_x_d = pos_x_q - XW'(1);
          default: ;
        endcase
        vb_cnt_d = 1'b0;
        state_d  = SETTLE;
      end
      SETTLE: begin
        if (vb_rise) begin
          if (vb_cnt_q) begin
            state_d = coll_now ? BNC : IDLE;
          end else begin
            vb_cnt_d = 1'b1;
          end
        end
      end
      BNC: begin
        unique case (move_dir_q)
          2'd0: pos_x_d = x_bnc_dn;
          2'd1: pos_y_d = y_bnc_dn;
          2'd2: pos_y_d = y_bnc_up;
          2'd3: pos_x_d = x_bnc_up;
          default: ;
        endcase
        color_d      = ~color_q;
        coll_frame_d = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk_vga) begin
    if (RESET) begin
      state_q      <= IDLE;
      pos_x_q      <= XW'(X_START);
      pos_y_q      <= YW'(Y_START);
      color_q      <= CW'(COLOR_INIT);
      move_dir_q   <= 2'd0;
      busy_q       <= 1'b0;
      cnt_q        <= '0;
      vblank_q     <= 1'b0;
      coll_flag_q  <= 1'b0;
      coll_frame_q <= 1'b0;
      vb_cnt_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      color_q      <= color_d;
      move_dir_q   <= move_dir_d;
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
      vblank_q     <= VBlank;
      coll_flag_q  <= coll_flag_d;
      coll_frame_q <= coll_frame_d;
      vb_cnt_q     <= vb_cnt_d;
    end
  end

  assign playerPosX  = pos_x_q;
  assign playerPosY  = pos_y_q;
  assign playerColor = color_q;
  assign move_dir    = move_dir_q;
  assign busy        = busy_q;

endmodule
